answer_entry_counter: RTL and testbench

- Parametrised successor of the basic button counter used for player answer entry in the math game.
- Up and down buttons pass through synchronisers and debouncers. Each press steps a modulo counter once, and a held button auto-repeats.
- The entered value is committed to a stable output, with a one-cycle valid pulse, when all buttons are released.
- Feeds the answer-compare logic and the 7-segment display path.

---
 rtl/answer_entry_counter.sv | 191 +++++++++++++++++++
 tb/tb_answer_entry_counter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/answer_entry_counter.sv
// Answer-entry counter for the math game.
// Up/down buttons are synchronised and debounced. Each accepted press steps a
// modulo counter, and a held button auto-repeats. The running value is
// committed to count_out_o, with a one-cycle valid pulse, once every button
// is released.
module answer_entry_counter #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned MAX_VAL         = 15,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  output logic [WIDTH-1:0] count_live_o,
  output logic [WIDTH-1:0] count_out_o,
  output logic             out_valid_o,
  output logic             wrap_o
);

  localparam int unsigned DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DBW-1:0]   DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]    DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT, LOCKOUT} state_e;

  // Index 0 is the up button, index 1 the down button throughout.
  logic [1:0]          sync_up_q;
  logic [1:0]          sync_dn_q;
  logic [1:0]          s;
  logic [1:0]          db_q;
  logic [1:0][DBW-1:0] db_cnt_q;

  state_e              state_q;
  logic                dir_up_q;
  logic [TW-1:0]       timer_q;
  logic [WIDTH-1:0]    count_live_q;
  logic [WIDTH-1:0]    count_out_q;
  logic                out_valid_q;
  logic                wrap_q;

  logic                press;
  logic                held;
  logic                none;
  logic                step_up;
  logic [WIDTH-1:0]    step_val;
  logic                step_wrap;

  // Two-flop synchronisers on the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!rst) begin
      sync_up_q <= '0;
      sync_dn_q <= '0;
    end else begin
      sync_up_q <= {sync_up_q[0], btn_up_i};
      sync_dn_q <= {sync_dn_q[0], btn_down_i};
    end
  end

  assign s = {sync_dn_q[1], sync_up_q[1]};

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i]     <= s[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_q[0] ^ db_q[1];
  assign held  = press && (db_q[0] == dir_up_q);
  assign none  = ~|db_q;

  // Next value for a step in the active direction, with its wrap flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    step_up   = (state_q == IDLE) ? db_q[0] : dir_up_q;
    step_val  = count_live_q;
    step_wrap = 1'b0;
    if (step_up) begin
      if (count_live_q == MAX_V) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val = count_live_q + 1'b1;
      end
    end else begin
      if (count_live_q == '0) begin
        step_val  = MAX_V;
        step_wrap = 1'b1;
      end else begin
        step_val = count_live_q - 1'b1;
      end
    end
  end

  // Press/repeat/lockout FSM with registered count, commit and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      dir_up_q     <= 1'b0;
      timer_q      <= '0;
      count_live_q <= '0;
      count_out_q  <= '0;
      out_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      if (clear_i) begin
        // A button still held after a clear must be released before stepping again.
        count_live_q <= '0;
        count_out_q  <= '0;
        timer_q      <= '0;
        state_q      <= none ? IDLE : LOCKOUT;
      end else if (state_q != IDLE && none) begin
        count_out_q <= count_live_q;
        out_valid_q <= 1'b1;
        state_q     <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (press) begin
              count_live_q <= step_val;
              wrap_q       <= step_wrap;
              dir_up_q     <= db_q[0];
              timer_q      <= '0;
              state_q      <= FIRST;
            end else if (&db_q) begin
              state_q <= LOCKOUT;
            end
          end
          FIRST: begin
            if (!held) begin
              state_q <= LOCKOUT;
            end else if (timer_q == DELAY_LAST) begin
              count_live_q <= step_val;
              wrap_q       <= step_wrap;
              timer_q      <= '0;
              state_q      <= REPEAT;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          REPEAT: begin
            if (!held) begin
              state_q <= LOCKOUT;
            end else if (timer_q == PERIOD_LAST) begin
              count_live_q <= step_val;
              wrap_q       <= step_wrap;
              timer_q      <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: begin
            state_q <= LOCKOUT;
          end
        endcase
      end
    end
  end

  assign count_live_o = count_live_q;
  assign count_out_o  = count_out_q;
  assign out_valid_o  = out_valid_q;
  assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_answer_entry_counter.sv
// Self-checking bench for answer_entry_counter: a MAX_VAL=15 and a MAX_VAL=9
// instance share the same stimulus and are both compared every cycle against
// a behavioural model, plus table vectors and hand sequences.
module tb_answer_entry_counter;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int MAXA = 15;
  localparam int MAXB = 9;

  localparam int M_IDLE = 0;
  localparam int M_HELD = 1;
  localparam int M_LOCK = 2;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       up;
  logic       dn;
  logic [3:0] live_a, out_a, live_b, out_b;
  logic       valid_a, wrap_a, valid_b, wrap_b;

  int vectors = 0;
  int miscompares = 0;

  answer_entry_counter #(.WIDTH(4), .MAX_VAL(MAXA), .DEBOUNCE_CYCLES(DB),
                         .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .rst(rst), .clear_i(clear), .btn_up_i(up), .btn_down_i(dn),
    .count_live_o(live_a), .count_out_o(out_a), .out_valid_o(valid_a), .wrap_o(wrap_a)
  );

  answer_entry_counter #(.WIDTH(4), .MAX_VAL(MAXB), .DEBOUNCE_CYCLES(DB),
                         .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .rst(rst), .clear_i(clear), .btn_up_i(up), .btn_down_i(dn),
    .count_live_o(live_b), .count_out_o(out_b), .out_valid_o(valid_b), .wrap_o(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: bit 0 = up, bit 1 = down. A level is accepted once the
  // trailing run of identical synchronised samples reaches DB; holds are timed
  // by age since the first step.
  typedef struct packed {
    bit [1:0] sync1;
    bit [1:0] s;
    bit [1:0] prev_s;
    bit [1:0] db;
    int       run_up;
    int       run_dn;
    int       mode;
    bit       dir;
    int       age;
    int       live;
    int       outv;
    bit       valid;
    bit       wrap;
  } model_t;

  model_t m, m9;

  function automatic model_t model_next(input model_t c, input bit rst_n, input bit clr,
                                        input bit bu, input bit bd, input int maxv);
    model_t n;
    bit u, d;
    bit do_step;
    n = c;
    n.valid = 1'b0;
    n.wrap  = 1'b0;
    if (!rst_n) return '0;
    n.sync1  = {bd, bu};
    n.s      = c.sync1;
    n.prev_s = c.s;
    n.run_up = (c.s[0] == c.prev_s[0]) ? ((c.run_up < 1000) ? c.run_up + 1 : c.run_up) : 1;
    n.run_dn = (c.s[1] == c.prev_s[1]) ? ((c.run_dn < 1000) ? c.run_dn + 1 : c.run_dn) : 1;
    if (c.s[0] != c.db[0] && n.run_up >= DB) n.db[0] = c.s[0];
    if (c.s[1] != c.db[1] && n.run_dn >= DB) n.db[1] = c.s[1];
    u = c.db[0];
    d = c.db[1];
    do_step = 1'b0;
    if (clr) begin
      n.live = 0;
      n.outv = 0;
      n.mode = (u || d) ? M_LOCK : M_IDLE;
    end else if (c.mode != M_IDLE && !u && !d) begin
      n.outv  = c.live;
      n.valid = 1'b1;
      n.mode  = M_IDLE;
    end else if (c.mode == M_IDLE) begin
      if (u != d) begin
        n.dir   = u;
        n.age   = 0;
        n.mode  = M_HELD;
        do_step = 1'b1;
      end else if (u && d) begin
        n.mode = M_LOCK;
      end
    end else if (c.mode == M_HELD) begin
      if (u != d && u == c.dir) begin
        n.age = c.age + 1;
        if (n.age == RD || (n.age > RD && (n.age - RD) % RP == 0)) do_step = 1'b1;
      end else begin
        n.mode = M_LOCK;
      end
    end
    if (do_step) begin
      if (n.dir) begin
        n.wrap = (c.live == maxv);
        n.live = (c.live + 1) % (maxv + 1);
      end else begin
        n.wrap = (c.live == 0);
        n.live = (c.live + maxv) % (maxv + 1);
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance both models with the pre-edge inputs, then compare.
  task automatic tick();
    @(posedge clk);
    m  = model_next(m,  rst, clear, up, dn, MAXA);
    m9 = model_next(m9, rst, clear, up, dn, MAXB);
    #1;
    check("a.live",  live_a,  m.live);
    check("a.out",   out_a,   m.outv);
    check("a.valid", valid_a, m.valid);
    check("a.wrap",  wrap_a,  m.wrap);
    check("b.live",  live_b,  m9.live);
    check("b.out",   out_b,   m9.outv);
    check("b.valid", valid_b, m9.valid);
    check("b.wrap",  wrap_b,  m9.wrap);
  endtask

  // Short single press (5 raw cycles, no repeat) followed by an idle gap.
  task automatic press(input bit is_up, output int wa, output int wb);
    wa = 0;
    wb = 0;
    for (int i = 0; i < 13; i++) begin
      up = is_up && (i < 5);
      dn = !is_up && (i < 5);
      tick();
      wa += int'(wrap_a);
      wb += int'(wrap_b);
    end
  endtask

  typedef struct {
    int n;
    bit rst_n;
    bit clr;
    bit bu;
    bit bd;
    int e_live;
    int e_out;
    bit e_valid;
    bit e_wrap;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int wa, wb, pulses, nonzero, seg, pat;
    rst = 1'b0; clear = 1'b0; up = 1'b0; dn = 1'b0;
    m = '0; m9 = '0;

    // Reset with toggling buttons, idle, then a 16-cycle up hold from edge E.
    tbl.push_back(vec_t'{1, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back(vec_t'{8, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back(vec_t'{6, 1, 0, 1, 0, 0, 0, 0, 0});  // E..E+5
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 1, 0, 0, 0});  // E+6 first step
    tbl.push_back(vec_t'{7, 1, 0, 1, 0, 1, 0, 0, 0});  // E+7..E+13
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 2, 0, 0, 0});  // E+14 first repeat
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 2, 0, 0, 0});  // E+15 last raw high
    tbl.push_back(vec_t'{2, 1, 0, 0, 0, 2, 0, 0, 0});  // E+16..E+17
    tbl.push_back(vec_t'{1, 1, 0, 0, 0, 3, 0, 0, 0});  // E+18 second repeat
    tbl.push_back(vec_t'{3, 1, 0, 0, 0, 3, 0, 0, 0});  // E+19..E+21
    tbl.push_back(vec_t'{1, 1, 0, 0, 0, 3, 3, 1, 0});  // E+22 commit
    tbl.push_back(vec_t'{2, 1, 0, 0, 0, 3, 3, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst_n; clear = tbl[i].clr; up = tbl[i].bu; dn = tbl[i].bd;
      repeat (tbl[i].n) tick();
      check($sformatf("tbl[%0d].live", i),  live_a,  tbl[i].e_live);
      check($sformatf("tbl[%0d].out", i),   out_a,   tbl[i].e_out);
      check($sformatf("tbl[%0d].valid", i), valid_a, tbl[i].e_valid);
      check($sformatf("tbl[%0d].wrap", i),  wrap_a,  tbl[i].e_wrap);
    end

    // Bounce: toggling every cycle never gets through the debouncer.
    for (int i = 0; i < 20; i++) begin
      up = (i < 10) ? ((i % 2) == 0) : 1'b0;
      tick();
      check("bounce.live",  live_a,  3);
      check("bounce.out",   out_a,   3);
      check("bounce.valid", valid_a, 0);
    end

    // Wrap both directions on the MAX_VAL=15 instance.
    for (int i = 0; i < 12; i++) press(1'b1, wa, wb);
    check("wrap.live15", live_a, 15);
    check("wrap.out15",  out_a,  15);
    press(1'b1, wa, wb);
    check("wrap.up.live", live_a, 0);
    check("wrap.up.cnt",  wa,     1);
    press(1'b0, wa, wb);
    check("wrap.dn.live", live_a, 15);
    check("wrap.dn.cnt",  wa,     1);

    // Clear while idle, then wrap both instances from 0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.a.live", live_a, 0);
    check("clr.a.out",  out_a,  0);
    check("clr.b.live", live_b, 0);
    check("clr.b.out",  out_b,  0);
    press(1'b0, wa, wb);
    check("wrap9.dn.a",   live_a, 15);
    check("wrap9.dn.b",   live_b, 9);
    check("wrap9.dn.wa",  wa,     1);
    check("wrap9.dn.wb",  wb,     1);
    press(1'b1, wa, wb);
    check("wrap9.up.a",   live_a, 0);
    check("wrap9.up.b",   live_b, 0);
    check("wrap9.up.wa",  wa,     1);
    check("wrap9.up.wb",  wb,     1);
    check("wrap9.up.out", out_b,  0);

    // Simultaneous buttons: up from E, down joins at E+10, both released at E+26.
    pulses = 0;
    for (int i = 0; i < 38; i++) begin
      up = (i < 26);
      dn = (i >= 10) && (i < 26);
      tick();
      pulses += int'(valid_a);
    end
    check("both.live",   live_a, 2);
    check("both.out",    out_a,  2);
    check("both.pulses", pulses, 1);

    // Clear while auto-repeating at 5: stepping stops until release, which commits 0.
    up = 1'b1;
    repeat (20) tick();
    check("clrhold.pre", live_a, 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrhold.live", live_a, 0);
    check("clrhold.out",  out_a,  0);
    pulses = 0;
    nonzero = 0;
    for (int i = 0; i < 27; i++) begin
      up = (i < 15);
      tick();
      pulses += int'(valid_a);
      if (live_a != 0) nonzero++;
    end
    check("clrhold.nonzero", nonzero, 0);
    check("clrhold.pulses",  pulses,  1);
    check("clrhold.commit",  out_a,   0);

    // Randomised segments checked against the model every cycle.
    seg = 0;
    pat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        pat = $urandom_range(0, 9);
        seg = $urandom_range(1, 30);
      end
      seg--;
      case (pat)
        0, 1, 2: begin up = 1'b0; dn = 1'b0; end
        3, 4, 5: begin up = 1'b1; dn = 1'b0; end
        6, 7:    begin up = 1'b0; dn = 1'b1; end
        8:       begin up = 1'b1; dn = 1'b1; end
        default: begin up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1)); end
      endcase
      clear = ($urandom_range(0, 39) == 0);
      rst   = !($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b1; clear = 1'b0; up = 1'b0; dn = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
